// File: rtl/dmem_bridge_pkg.sv
// Shared definitions for the core data-memory bridge: FSM encoding,
// default response timeout and the word-alignment helper.
package dmem_bridge_pkg;

  localparam int unsigned DEFAULT_TIMEOUT = 64;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REQ      = 2'd1,
    WAIT_RSP = 2'd2,
    DONE     = 2'd3
  } state_e;

  function automatic logic is_word_aligned(input logic [31:0] a);
    return (a[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/dmem_bridge.sv
// Bridges the single-cycle core data port to a valid/ready memory with a
// response timeout; stalls the core via Dwait until the access completes.
module dmem_bridge
  import dmem_bridge_pkg::*;
#(
  parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memaccess,
  input  logic        memwrite,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        Dwait,
  output logic        err,
  output logic        m_req_valid,
  input  logic        m_req_ready,
  output logic        m_we,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  input  logic        m_rsp_valid,
  input  logic [31:0] m_rdata
);

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  state_e      state_q;
  logic [7:0]  cnt_q;
  logic [31:0] rdata_q;
  logic        err_q;
  logic        m_req_valid_q;
  logic        m_we_q;
  logic [31:0] m_addr_q;
  logic [31:0] m_wdata_q;

  // Access sequencer; err_q doubles as the error flag and is only ever high in DONE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      cnt_q         <= 8'd0;
      rdata_q       <= 32'd0;
      err_q         <= 1'b0;
      m_req_valid_q <= 1'b0;
      m_we_q        <= 1'b0;
      m_addr_q      <= 32'd0;
      m_wdata_q     <= 32'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (memaccess) begin
            if (is_word_aligned(addr)) begin
              m_we_q        <= memwrite;
              m_addr_q      <= addr;
              m_wdata_q     <= wdata;
              m_req_valid_q <= 1'b1;
              state_q       <= REQ;
            end else begin
              err_q   <= 1'b1;
              state_q <= DONE;
            end
          end
        end
        REQ: begin
          if (m_req_ready) begin
            m_req_valid_q <= 1'b0;
            cnt_q         <= 8'd0;
            state_q       <= WAIT_RSP;
          end
        end
        WAIT_RSP: begin
          // A response on the final counted cycle beats the timeout.
          if (m_rsp_valid) begin
            if (!m_we_q) begin
              rdata_q <= m_rdata;
            end
            state_q <= DONE;
          end else if (cnt_q == TO_LAST) begin
            err_q   <= 1'b1;
            rdata_q <= 32'd0;
            state_q <= DONE;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        DONE: begin
          err_q   <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          err_q         <= 1'b0;
          m_req_valid_q <= 1'b0;
          state_q       <= IDLE;
        end
      endcase
    end
  end

  assign Dwait       = memaccess && (state_q != DONE);
  assign rdata       = rdata_q;
  assign err         = err_q;
  assign m_req_valid = m_req_valid_q;
  assign m_we        = m_we_q;
  assign m_addr      = m_addr_q;
  assign m_wdata     = m_wdata_q;

endmodule

// File: tb/tb_dmem_bridge.sv
// Randomized bench for dmem_bridge: each access is planned up front (ready
// delay, response delay) and the per-cycle outputs follow from that plan.
module tb_dmem_bridge;

  localparam int TO = 64;

  logic        clk;
  logic        reset;
  logic        memaccess;
  logic        memwrite;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        Dwait;
  logic        err;
  logic        m_req_valid;
  logic        m_req_ready;
  logic        m_we;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic        m_rsp_valid;
  logic [31:0] m_rdata;

  int checks   = 0;
  int failures = 0;

  logic        exp_dwait;
  logic        exp_valid;
  logic        exp_err;
  logic        exp_we;
  logic [31:0] exp_maddr;
  logic [31:0] exp_mwdata;
  logic [31:0] exp_rdata;

  int obs_dwait = 0;
  int obs_valid = 0;
  int obs_err   = 0;

  dmem_bridge #(.TIMEOUT(TO)) dut (
    .clk         (clk),
    .reset       (reset),
    .memaccess   (memaccess),
    .memwrite    (memwrite),
    .addr        (addr),
    .wdata       (wdata),
    .rdata       (rdata),
    .Dwait       (Dwait),
    .err         (err),
    .m_req_valid (m_req_valid),
    .m_req_ready (m_req_ready),
    .m_we        (m_we),
    .m_addr      (m_addr),
    .m_wdata     (m_wdata),
    .m_rsp_valid (m_rsp_valid),
    .m_rdata     (m_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  // Compare every cycle on the falling edge, away from the active edge.
  always @(negedge clk) begin
    chk("dwait",       {31'd0, Dwait},       {31'd0, exp_dwait});
    chk("m_req_valid", {31'd0, m_req_valid}, {31'd0, exp_valid});
    chk("err",         {31'd0, err},         {31'd0, exp_err});
    chk("m_we",        {31'd0, m_we},        {31'd0, exp_we});
    chk("m_addr",      m_addr,               exp_maddr);
    chk("m_wdata",     m_wdata,              exp_mwdata);
    chk("rdata",       rdata,                exp_rdata);
    if (Dwait)       obs_dwait++;
    if (m_req_valid) obs_valid++;
    if (err)         obs_err++;
  end

  // One access: idle cycle, d+1 request cycles, then up to TO wait cycles
  // (response on wait cycle r, none if r >= TO), then the done cycle.
  task automatic run_txn(input logic we, input logic [31:0] a, input logic [31:0] wd,
                         input int d, input int r, input logic [31:0] rd, input int rst_k);
    bit misal;
    bit to;
    int n_wait;
    int total;
    int j;
    misal  = (a[1:0] != 2'b00);
    to     = (r >= TO);
    n_wait = to ? TO : r + 1;
    total  = misal ? 2 : (d + n_wait + 3);
    for (int k = 0; k < total; k++) begin
      memaccess   = 1'b1;
      memwrite    = we;
      addr        = a;
      wdata       = wd;
      m_req_ready = 1'($urandom_range(0, 1));
      m_rsp_valid = 1'($urandom_range(0, 1));
      m_rdata     = $urandom;
      exp_dwait   = 1'b1;
      exp_valid   = 1'b0;
      exp_err     = 1'b0;
      if (k == rst_k) begin
        reset       = 1'b1;
        m_rsp_valid = 1'b1;
        exp_rdata   = 32'd0;
        exp_we      = 1'b0;
        exp_maddr   = 32'd0;
        exp_mwdata  = 32'd0;
        @(posedge clk); #1;
        reset       = 1'b0;
        memaccess   = 1'b0;
        m_rsp_valid = 1'b1;
        exp_dwait   = 1'b0;
        @(posedge clk); #1;
        return;
      end
      if (misal) begin
        if (k == 1) begin
          exp_dwait = 1'b0;
          exp_err   = 1'b1;
        end
      end else if (k >= 1 && k <= d + 1) begin
        exp_valid   = 1'b1;
        m_req_ready = (k == d + 1);
        if (k == 1) begin
          exp_we     = we;
          exp_maddr  = a;
          exp_mwdata = wd;
        end
      end else if (k >= d + 2 && k < d + 2 + n_wait) begin
        j = k - (d + 2);
        m_rsp_valid = (j == r);
        if (j == r) m_rdata = rd;
      end else if (k == total - 1) begin
        exp_dwait = 1'b0;
        exp_err   = to;
        if (to) exp_rdata = 32'd0;
        else if (!we) exp_rdata = rd;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic gap(input int n);
    for (int k = 0; k < n; k++) begin
      memaccess   = 1'b0;
      memwrite    = 1'($urandom_range(0, 1));
      addr        = $urandom;
      wdata       = $urandom;
      m_req_ready = 1'($urandom_range(0, 1));
      m_rsp_valid = 1'($urandom_range(0, 1));
      m_rdata     = $urandom;
      exp_dwait   = 1'b0;
      exp_valid   = 1'b0;
      exp_err     = 1'b0;
      @(posedge clk); #1;
    end
  endtask

  task automatic random_txn();
    logic [31:0] a;
    int pick;
    int r;
    a = $urandom;
    if ($urandom_range(0, 7) != 0) a[1:0] = 2'b00;
    else a[1:0] = 2'($urandom_range(1, 3));
    pick = int'($urandom_range(0, 19));
    if (pick < 15)      r = int'($urandom_range(0, 5));
    else if (pick < 17) r = TO - 1;
    else                r = 500;
    run_txn(1'($urandom_range(0, 1)), a, $urandom, int'($urandom_range(0, 4)), r, $urandom, -1);
    gap(int'($urandom_range(0, 2)));
  endtask

  int s_dw, s_va, s_er;

  task automatic snap();
    s_dw = obs_dwait;
    s_va = obs_valid;
    s_er = obs_err;
  endtask

  initial begin
    reset = 1'b1; memaccess = 1'b0; memwrite = 1'b0; addr = 32'd0; wdata = 32'd0;
    m_req_ready = 1'b0; m_rsp_valid = 1'b0; m_rdata = 32'd0;
    exp_dwait = 1'b0; exp_valid = 1'b0; exp_err = 1'b0; exp_we = 1'b0;
    exp_maddr = 32'd0; exp_mwdata = 32'd0; exp_rdata = 32'd0;
    @(posedge clk); #1;
    memaccess = 1'b1;
    exp_dwait = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    memaccess = 1'b0;
    exp_dwait = 1'b0;
    @(posedge clk); #1;

    snap();
    run_txn(1'b0, 32'h0000_0100, 32'h0, 0, 3, 32'hCAFE_F00D, -1);
    chk("load_dwait_cycles", 32'(obs_dwait - s_dw), 32'd6);
    chk("load_rdata", rdata, 32'hCAFE_F00D);
    chk("load_err_cycles", 32'(obs_err - s_er), 32'd0);

    snap();
    run_txn(1'b1, 32'h0000_0204, 32'h1234_5678, 5, 1, 32'hDEAD_BEEF, -1);
    chk("store_valid_cycles", 32'(obs_valid - s_va), 32'd6);
    chk("store_m_we", {31'd0, m_we}, 32'd1);
    chk("store_m_wdata", m_wdata, 32'h1234_5678);
    chk("store_rdata_kept", rdata, 32'hCAFE_F00D);

    snap();
    run_txn(1'b0, 32'h0000_0103, 32'h0, 0, 0, 32'h0, -1);
    chk("misal_valid_cycles", 32'(obs_valid - s_va), 32'd0);
    chk("misal_dwait_cycles", 32'(obs_dwait - s_dw), 32'd1);
    chk("misal_err_cycles", 32'(obs_err - s_er), 32'd1);

    snap();
    run_txn(1'b0, 32'h0000_0300, 32'h0, 0, 1000, 32'h0, -1);
    chk("timeout_dwait_cycles", 32'(obs_dwait - s_dw), 32'd66);
    chk("timeout_err_cycles", 32'(obs_err - s_er), 32'd1);
    chk("timeout_rdata", rdata, 32'd0);

    snap();
    run_txn(1'b0, 32'h0000_0304, 32'h0, 0, TO - 1, 32'hA5A5_1234, -1);
    chk("edge_rsp_dwait_cycles", 32'(obs_dwait - s_dw), 32'd66);
    chk("edge_rsp_err_cycles", 32'(obs_err - s_er), 32'd0);
    chk("edge_rsp_rdata", rdata, 32'hA5A5_1234);
    gap(1);

    for (int i = 0; i < 150; i++) random_txn();

    run_txn(1'b0, 32'h0000_0400, 32'h0, 0, 0, 32'h1111_2222, -1);
    snap();
    run_txn(1'b0, 32'h0000_0500, 32'h0, 1, 500, 32'h0, 5);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_err_cycles", 32'(obs_err - s_er), 32'd0);
    chk("rst_valid", {31'd0, m_req_valid}, 32'd0);
    gap(2);

    for (int i = 0; i < 20; i++) random_txn();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
